// File: rtl/pipe_pkg.sv
// Purpose : shared definitions for the MEM-stage data cache (FSM states, word width).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int WORD_W = 32;

  // Fixed 2-bit encoding so the states are stable across tools and waveforms.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_dcache_if.sv
// Purpose : handshake bundles around the data cache.
//   dcache_cpu_if : EX/MEM request (mwmem, mm2reg, malu, mb), imem_ready in; mem_ready, mdo out.
//   dcache_mem_if : single-outstanding req/ack link to main memory.
// Latency : n/a (wires only).
// Backpressure: cpu side via mem_ready/imem_ready; memory side via mem_ack.
interface dcache_cpu_if;
  import pipe_pkg::*;

  logic              imem_ready;
  logic              mwmem;
  logic              mm2reg;
  logic [WORD_W-1:0] malu;
  logic [WORD_W-1:0] mb;
  logic              mem_ready;
  logic [WORD_W-1:0] mdo;

  // master = pipeline, slave = cache
  modport master (output imem_ready, mwmem, mm2reg, malu, mb,
                  input  mem_ready, mdo);
  modport slave  (input  imem_ready, mwmem, mm2reg, malu, mb,
                  output mem_ready, mdo);
endinterface

interface dcache_mem_if;
  import pipe_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  // master = cache, slave = main memory
  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/pipe_dcache_array.sv
// Purpose : tag/valid/data storage for the direct-mapped cache, one word per line.
//   clock, resetn; read port i_rd_index/i_rd_tag -> o_hit/o_rdata (combinational);
//   write port i_we/i_wr_index/i_wr_tag/i_wr_data (synchronous, sets the valid bit).
// Latency : read 0 cycles, write lands on the next rising edge; no backpressure.
module dcache_array
  import pipe_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_W      = 26
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [TAG_W-1:0]      i_rd_tag,
  output logic                  o_hit,
  output logic [WORD_W-1:0]     o_rdata,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [WORD_W-1:0]     i_wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [WORD_W-1:0] r_data [LINES];

  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_hit   = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rdata = r_data[i_rd_index];

endmodule

// File: rtl/pipe_dcache.sv
// Purpose : MEM-stage direct-mapped, write-through, no-write-allocate data cache.
//   clock, resetn; cpu (dcache_cpu_if.slave): request + mem_ready/mdo; mem (dcache_mem_if.master).
// Latency : load hit 0 stalls; miss/store 1 + ack wait, mem_ready rises the cycle after mem_ack;
//   holds in DONE (no new traffic) while imem_ready is low.
module pipe_dcache
  import pipe_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic         clock,
  input  logic         resetn,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic [WORD_W-1:0] r_fill;

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_store;
  logic                  w_load;
  logic                  w_hit;
  logic [WORD_W-1:0]     w_rdata;
  logic                  w_arr_we;
  logic [WORD_W-1:0]     w_arr_wdata;
  logic                  w_mem_ready;
  logic [WORD_W-1:0]     w_mdo;
  logic                  w_unused;

  assign w_index  = cpu.malu[INDEX_BITS+1:2];
  assign w_tag    = cpu.malu[ADDR_W-1:INDEX_BITS+2];
  assign w_unused = &{1'b0, cpu.malu[1:0]};

  // Both strobes high is illegal; resolve it as a store so behaviour is deterministic.
  assign w_store = cpu.mwmem;
  assign w_load  = cpu.mm2reg & ~cpu.mwmem;

  // Refill writes the returned word; a write-through updates the line only if it
  // still holds this address (no-write-allocate).
  assign w_arr_we    = mem.mem_ack &
                       ((r_state == RD_MISS) | ((r_state == WR_THRU) & w_hit));
  assign w_arr_wdata = (r_state == RD_MISS) ? mem.mem_rdata : r_mem_wdata;

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clock      (clock),
    .resetn     (resetn),
    .i_rd_index (w_index),
    .i_rd_tag   (w_tag),
    .o_hit      (w_hit),
    .o_rdata    (w_rdata),
    .i_we       (w_arr_we),
    .i_wr_index (w_index),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_arr_wdata)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_fill      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_store) begin
            r_state     <= WR_THRU;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {cpu.malu[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= cpu.mb;
          end else if (w_load && !w_hit) begin
            r_state    <= RD_MISS;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {cpu.malu[ADDR_W-1:2], 2'b00};
          end
        end
        RD_MISS: begin
          if (mem.mem_ack) begin
            r_fill    <= mem.mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end
        end
        WR_THRU: begin
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          // Wait here until the pipeline actually advances, so a stalled
          // store cannot be issued a second time.
          if (cpu.imem_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_mem_ready = 1'b0;
    w_mdo       = '0;
    case (r_state)
      IDLE: begin
        w_mem_ready = ~(cpu.mwmem | cpu.mm2reg) | (w_load & w_hit);
        if (w_load && w_hit) begin
          w_mdo = w_rdata;
        end
      end
      DONE: begin
        w_mem_ready = 1'b1;
        if (w_load) begin
          w_mdo = r_fill;
        end
      end
      default: begin
        w_mem_ready = 1'b0;
      end
    endcase
  end

  assign cpu.mem_ready = w_mem_ready;
  assign cpu.mdo       = w_mdo;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_pipe_dcache.sv
// Purpose : self-checking bench for pipe_dcache: directed scenarios then random loads/stores.
// Latency : expectations derived from a line-address model plus a flat memory image.
// Backpressure: memory acks after a random/forced delay; imem_ready stalls exercised in DONE.
module tb_pipe_dcache;
  import pipe_pkg::*;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  dcache_cpu_if cpu();
  dcache_mem_if mem();

  pipe_dcache #(.INDEX_BITS(4), .ADDR_W(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .cpu    (cpu),
    .mem    (mem)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Background contents of memory for words never written.
  function automatic logic [31:0] init_val(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Environment memory (what the responder serves) and reference memory (what the model expects).
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] env_rd(input logic [31:0] wa);
    return env_mem.exists(wa) ? env_mem[wa] : init_val(wa);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_val(wa);
  endfunction

  // Reference cache: which word address each of the 16 lines currently holds.
  logic [31:0] line_addr [16];
  bit          line_vld  [16];

  // ---------------- memory responder ----------------
  int          req_count   = 0;
  logic [31:0] last_addr   = '0;
  logic [31:0] last_wdata  = '0;
  logic        last_we     = 1'b0;
  int          ack_cyc     = -1;
  int          force_delay = -1;
  bit          hold_ack    = 1'b0;

  initial begin
    bit pending;
    int wait_cnt;
    pending      = 1'b0;
    wait_cnt     = 0;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clock);
      #3;
      mem.mem_ack = 1'b0;
      if (!resetn) begin
        pending = 1'b0;
      end else if (pending) begin
        if (hold_ack) begin
          pending = 1'b1;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          mem.mem_ack = 1'b1;
          if (last_we) env_mem[last_addr] = last_wdata;
          else         mem.mem_rdata = env_rd(last_addr);
          ack_cyc = cyc;
          pending = 1'b0;
        end
      end else if (mem.mem_req) begin
        pending    = 1'b1;
        req_count++;
        last_addr  = mem.mem_addr;
        last_we    = mem.mem_we;
        last_wdata = mem.mem_wdata;
        wait_cnt   = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
      end else if ($urandom_range(0, 7) == 0) begin
        // Stray ack while nothing is outstanding must be ignored.
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- transaction driver + checker ----------------
  // Called at posedge+1; returns at posedge+1 after the request has been consumed.
  task automatic do_op(input bit st, input bit ld, input logic [31:0] addr,
                       input logic [31:0] data, input int stall);
    logic [31:0] wa;
    int          idx;
    bit          is_ld;
    bit          hit;
    int          rc0;
    logic [31:0] exp;
    int          n;
    bit          done;
    wa    = {addr[31:2], 2'b00};
    idx   = int'(addr[5:2]);
    is_ld = ld && !st;
    hit   = is_ld && line_vld[idx] && (line_addr[idx] == wa);
    exp   = ref_rd(wa);
    cpu.mwmem      = st;
    cpu.mm2reg     = ld;
    cpu.malu       = addr;
    cpu.mb         = data;
    cpu.imem_ready = 1'b1;
    rc0 = req_count;
    #1;
    if (hit) begin
      check("hit_ready", {31'b0, cpu.mem_ready}, 32'd1);
      check("hit_mdo", cpu.mdo, exp);
      @(posedge clock);
      #1;
      check("hit_no_req", {31'b0, mem.mem_req}, 32'd0);
    end else begin
      check("miss_ready_low", {31'b0, cpu.mem_ready}, 32'd0);
      n    = 0;
      done = 1'b0;
      while (!done && n < 100) begin
        @(posedge clock);
        #1;
        n++;
        if (cpu.mem_ready) done = 1'b1;
      end
      if (!done) begin
        check("timeout_mem_ready", 32'd0, 32'd1);
      end else begin
        check("ready_after_ack", cyc, ack_cyc + 1);
        check("req_count", req_count - rc0, 32'd1);
        check("req_addr", last_addr, wa);
        check("req_we", {31'b0, last_we}, {31'b0, st});
        if (st) check("req_wdata", last_wdata, data);
        check("done_mdo", cpu.mdo, is_ld ? exp : 32'd0);
        if (stall > 0) begin
          cpu.imem_ready = 1'b0;
          repeat (stall) begin
            @(posedge clock);
            #1;
            check("stall_ready", {31'b0, cpu.mem_ready}, 32'd1);
            check("stall_req", {31'b0, mem.mem_req}, 32'd0);
          end
          check("stall_req_count", req_count - rc0, 32'd1);
          cpu.imem_ready = 1'b1;
        end
        @(posedge clock);
        #1;
      end
    end
    // Model update: write-through memory, refill on load miss, no allocate on store.
    if (st) begin
      ref_mem[wa] = data;
    end else if (is_ld && !hit) begin
      line_vld[idx]  = 1'b1;
      line_addr[idx] = wa;
    end
  endtask

  task automatic idle_cycle();
    cpu.mwmem  = 1'b0;
    cpu.mm2reg = 1'b0;
    #1;
    check("idle_ready", {31'b0, cpu.mem_ready}, 32'd1);
    check("idle_mdo", cpu.mdo, 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      line_vld[i]  = 1'b0;
      line_addr[i] = '0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] tagv;
    int          kind;
    model_reset();
    cpu.imem_ready = 1'b1;
    cpu.mwmem      = 1'b0;
    cpu.mm2reg     = 1'b0;
    cpu.malu       = '0;
    cpu.mb         = '0;
    env_mem[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_req", {31'b0, mem.mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem.mem_we}, 32'd0);
    check("rst_mem_addr", mem.mem_addr, 32'd0);
    check("rst_mem_wdata", mem.mem_wdata, 32'd0);
    check("rst_ready", {31'b0, cpu.mem_ready}, 32'd1);
    check("rst_mdo", cpu.mdo, 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Reset in the middle of a refill.
    hold_ack   = 1'b1;
    cpu.mm2reg = 1'b1;
    cpu.malu   = 32'h40;
    repeat (3) @(posedge clock);
    #1;
    check("midmiss_req", {31'b0, mem.mem_req}, 32'd1);
    resetn = 1'b0;
    #1;
    check("midmiss_rst_req", {31'b0, mem.mem_req}, 32'd0);
    check("midmiss_rst_ready", {31'b0, cpu.mem_ready}, 32'd0);
    @(posedge clock);
    #1;
    resetn   = 1'b1;
    hold_ack = 1'b0;
    model_reset();
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);   // misses again after reset

    // Cold load with 3-cycle memory latency, then a hit.
    model_reset();
    resetn = 1'b0;
    #1;
    @(posedge clock);
    #1;
    resetn      = 1'b1;
    force_delay = 2;
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    force_delay = -1;
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);

    // Store hit then load hit sees new data.
    do_op(1'b1, 1'b0, 32'h40, 32'h1234_5678, 0);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    check("store_hit_mem", env_rd(32'h40), 32'h1234_5678);

    // Store miss is not allocated.
    do_op(1'b1, 1'b0, 32'h80, 32'hCAFE_0080, 0);
    do_op(1'b0, 1'b1, 32'h80, 32'h0, 0);

    // Same-index conflict.
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    do_op(1'b0, 1'b1, 32'h440, 32'h0, 0);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);

    // Store finishing into a 4-cycle instruction-side stall.
    do_op(1'b1, 1'b0, 32'h44, 32'hA5A5_0044, 4);
    idle_cycle();

    // Random mix over a small address pool to create hits and conflicts.
    for (int i = 0; i < 200; i++) begin
      tagv = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) tagv = tagv | 32'h0100_0000;
      a    = (tagv << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) idle_cycle();
      if (kind <= 5)      do_op(1'b0, 1'b1, a, 32'h0, ($urandom_range(0, 3) == 0) ? 2 : 0);
      else if (kind <= 8) do_op(1'b1, 1'b0, a, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      else                do_op(1'b1, 1'b1, a, $urandom, 0);
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
